// File: rtl/qs_resp_pkg.sv
// qs_resp_pkg: shared types and constants for the qsort SRAM responder.
// Holds the FSM state encoding, the latency counter width and the default window base.
package qs_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      ACK  = 2'b10
   } state_e;

   localparam int LAT_W = 4;

   localparam logic [31:0] QS_BASE_ADDR = 32'h3800_0000;

endpackage

// File: rtl/qs_resp_mem.sv
// qs_resp_mem: DEPTH_WORDS x 32 single-port synchronous RAM with byte-write enables.
// Ports: clk_i, re_i (registered read), be_i[3:0] (byte writes), addr_i, wdata_i, rdata_o.
module qs_resp_mem #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic                           clk_i,
   input  logic                           re_i,
   input  logic [3:0]                     be_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
   input  logic [31:0]                    wdata_i,
   output logic [31:0]                    rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/qs_wb_sram_resp.sv
// qs_wb_sram_resp: Wishbone single-word responder for the qsort Q[]/QR[] SRAM window.
// Ports: wb_clk_i, wb_rst_ni, wbs_cyc/stb/we/sel/adr/dat_i, wbs_ack_o, wbs_dat_o, busy_o.
// Optional: define QS_RESP_SEQ_FAST_EN for latency-1 reads of the next sequential word.
module qs_wb_sram_resp
   import qs_resp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = QS_BASE_ADDR,
   parameter int          DEPTH_WORDS = 256,
   parameter int          RD_LAT      = 3,
   parameter int          WR_LAT      = 1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        busy_o
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [LAT_W-1:0] RD_CNT = LAT_W'(RD_LAT - 1);
   localparam logic [LAT_W-1:0] WR_CNT = LAT_W'(WR_LAT - 1);

   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic             we_q;
   logic [3:0]       sel_q;
   logic [AW-1:0]    idx_q;
   logic [31:0]      wdat_q;

   logic [31:0]      offs;
   logic             hit;
   logic             req;
   logic [AW-1:0]    bus_idx;
   logic [LAT_W-1:0] ld_cnt;

   logic             ack;
   logic             mem_re;
   logic [3:0]       mem_be;
   logic [AW-1:0]    mem_addr;
   logic [31:0]      mem_rdata;

   // Wrapping subtract makes addresses below the base fall out as misses.
   assign offs    = wbs_adr_i - BASE_ADDR;
   assign hit     = offs < WIN_BYTES;
   assign bus_idx = offs[AW+1:2];
   assign req     = wbs_cyc_i & wbs_stb_i & hit;

`ifdef QS_RESP_SEQ_FAST_EN
   logic [AW-1:0] last_q;
   logic          lv_q;
   logic          seq_hit;

   assign seq_hit = lv_q & (bus_idx == last_q + AW'(1));
   assign ld_cnt  = wbs_we_i ? WR_CNT : (seq_hit ? '0 : RD_CNT);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         last_q <= '0;
         lv_q   <= 1'b0;
      end else if (ack && !we_q) begin
         last_q <= idx_q;
         lv_q   <= 1'b1;
      end else if (ack && we_q && idx_q == last_q) begin
         lv_q   <= 1'b0;
      end
   end
`else
   assign ld_cnt = wbs_we_i ? WR_CNT : RD_CNT;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         idx_q   <= '0;
         wdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && req) begin
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            idx_q  <= bus_idx;
            wdat_q <= wbs_dat_i;
         end
      end
   end

   // Count reaching 1 in WAIT means the next cycle is the ack cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               cnt_d   = ld_cnt;
               state_d = (ld_cnt == '0) ? ACK : WAIT;
            end
         end
         WAIT: begin
            if (!wbs_cyc_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q <= LAT_W'(1)) begin
               state_d = ACK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read data is fetched on the edge entering ACK; writes land on the ACK edge.
   always_comb begin
      busy_o   = (state_q != IDLE);
      ack      = (state_q == ACK) & wbs_cyc_i;
      mem_addr = (state_q == IDLE) ? bus_idx : idx_q;
      mem_re   = (state_d == ACK) &
                 ((state_q == IDLE) ? ~wbs_we_i : ~we_q);
      mem_be   = (ack && we_q) ? sel_q : 4'b0000;
   end

   qs_resp_mem #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_mem (
      .clk_i  (wb_clk_i),
      .re_i   (mem_re),
      .be_i   (mem_be),
      .addr_i (mem_addr),
      .wdata_i(wdat_q),
      .rdata_o(mem_rdata)
   );

   assign wbs_ack_o = ack;
   assign wbs_dat_o = (ack && !we_q) ? mem_rdata : 32'h0;

endmodule
